fp16_mult_arbiter: RTL and testbench

FP16_MULT_ARBITER -- requirements
Module: fp16_mult_arbiter

---
 rtl/fp16_mult_arbiter_pkg.sv | 15 +
 rtl/fp16_mult_arbiter_if.sv | 19 +
 rtl/fp16_mult_arbiter_rr_arbiter.sv | 47 ++++
 rtl/fp16_mult_arbiter.sv | 98 +++++++++
 tb/tb_fp16_mult_arbiter.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/fp16_mult_arbiter_pkg.sv
// Shared constants and types for the fp16 multiplier arbiter.
package fp16_arb_pkg;
  localparam int FP16_W   = 16;
  localparam int NREQ_DEF = 4;
  localparam int LAT_DEF  = 3;
  localparam int NREQ_MAX = 8;
  localparam int CNT_W    = 16;
  // Index field is sized for the largest legal NREQ so one tag type serves every build.
  localparam int IDX_W    = $clog2(NREQ_MAX);

  typedef struct packed {
    logic             vld;
    logic [IDX_W-1:0] idx;
  } tag_t;
endpackage

// File: rtl/fp16_mult_arbiter_if.sv
// Requester-side bundle: operand requests in, one-hot grant and tagged results out.
interface fp16_mult_arbiter_if
  import fp16_arb_pkg::*;
#(
  parameter int NREQ = NREQ_DEF
) ();
  logic [NREQ-1:0]             req_valid;
  logic [NREQ-1:0][FP16_W-1:0] req_a;
  logic [NREQ-1:0][FP16_W-1:0] req_b;
  logic [NREQ-1:0]             req_ready;
  logic [NREQ-1:0]             res_valid;
  logic [FP16_W-1:0]           res_data;
  logic                        busy;

  modport master (output req_valid, req_a, req_b,
                  input  req_ready, res_valid, res_data, busy);
  modport slave  (input  req_valid, req_a, req_b,
                  output req_ready, res_valid, res_data, busy);
endinterface

// File: rtl/fp16_mult_arbiter_rr_arbiter.sv
// Round-robin arbiter: grants the first request at or above the pointer, wrapping to 0.
module rr_arbiter
  import fp16_arb_pkg::*;
#(
  parameter int NREQ = NREQ_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NREQ-1:0]  req,
  output logic [NREQ-1:0]  gnt,
  output logic [IDX_W-1:0] gnt_idx
);
  localparam int PW = $clog2(NREQ);

  logic [PW-1:0]    ptr_q, ptr_d;
  logic             hi_f;
  logic [IDX_W-1:0] hi_i, lo_i;

  always_comb begin
    hi_f    = 1'b0;
    hi_i    = '0;
    lo_i    = '0;
    gnt     = '0;
    gnt_idx = '0;
    ptr_d   = ptr_q;
    // Descending scan leaves the lowest set index overall and the lowest at/above ptr.
    for (int i = NREQ-1; i >= 0; i--) begin
      if (req[i]) begin
        lo_i = IDX_W'(i);
        if (i >= int'(ptr_q)) begin
          hi_f = 1'b1;
          hi_i = IDX_W'(i);
        end
      end
    end
    if (|req) begin
      gnt_idx = hi_f ? hi_i : lo_i;
      gnt     = NREQ'(1) << gnt_idx;
      ptr_d   = (gnt_idx == IDX_W'(NREQ-1)) ? '0 : PW'(gnt_idx + 1'b1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end
endmodule

// File: rtl/fp16_mult_arbiter.sv
// Shares one pipelined fp16 multiplier among NREQ requesters and routes products back by tag.
// Optional grant statistics counters are built when FP16_ARB_STATS_EN is defined.
module fp16_mult_arbiter
  import fp16_arb_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int LAT  = LAT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  fp16_mult_arbiter_if.slave rq,
  output logic [FP16_W-1:0] mult_a,
  output logic [FP16_W-1:0] mult_b,
  input  logic [FP16_W-1:0] mult_x,
  input  logic [2:0]        stat_sel,
  output logic [CNT_W-1:0]  stat_cnt
);
  logic [NREQ-1:0]   gnt;
  logic [IDX_W-1:0]  gnt_idx;
  logic [FP16_W-1:0] mult_a_q, mult_a_d, mult_b_q, mult_b_d;
  tag_t [LAT:0]      tag_q, tag_d;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (rq.req_valid),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  assign rq.req_ready = gnt;
  assign mult_a       = mult_a_q;
  assign mult_b       = mult_b_q;
  assign rq.res_data  = mult_x;

  always_comb begin
    mult_a_d = mult_a_q;
    mult_b_d = mult_b_q;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) begin
        mult_a_d = rq.req_a[i];
        mult_b_d = rq.req_b[i];
      end
    end
  end

  // Tag stage k is live k+1 cycles after the transfer; stage LAT lines up with mult_x.
  always_comb begin
    tag_d[0].vld = |gnt;
    tag_d[0].idx = gnt_idx;
    for (int k = 1; k <= LAT; k++) tag_d[k] = tag_q[k-1];
  end

  always_comb begin
    rq.res_valid = '0;
    rq.busy      = 1'b0;
    for (int i = 0; i < NREQ; i++)
      rq.res_valid[i] = tag_q[LAT].vld && (tag_q[LAT].idx == IDX_W'(i));
    for (int k = 0; k <= LAT; k++) rq.busy = rq.busy | tag_q[k].vld;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mult_a_q <= '0;
      mult_b_q <= '0;
      tag_q    <= '0;
    end else begin
      mult_a_q <= mult_a_d;
      mult_b_q <= mult_b_d;
      tag_q    <= tag_d;
    end
  end

`ifdef FP16_ARB_STATS_EN
  logic [NREQ-1:0][CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    for (int i = 0; i < NREQ; i++)
      if (gnt[i] && cnt_q[i] != '1) cnt_d[i] = cnt_q[i] + 1'b1;
  end

  always_comb begin
    stat_cnt = '0;
    for (int i = 0; i < NREQ; i++)
      if (stat_sel == 3'(i)) stat_cnt = cnt_q[i];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end
`else
  logic unused_stat_sel;
  assign unused_stat_sel = ^stat_sel;
  assign stat_cnt        = '0;
`endif
endmodule

// File: tb/tb_fp16_mult_arbiter.sv
// Scoreboard bench for fp16_mult_arbiter: directed issues push expected results, a monitor pops them.
module tb_fp16_mult_arbiter;
  import fp16_arb_pkg::*;
  localparam int NREQ = 4;
  localparam int LAT  = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] mult_a, mult_b, mult_x;
  logic [2:0]  stat_sel;
  logic [15:0] stat_cnt;

  fp16_mult_arbiter_if #(.NREQ(NREQ)) rq ();

  fp16_mult_arbiter #(.NREQ(NREQ), .LAT(LAT)) dut (
    .clk      (clk),
    .rst      (rst),
    .rq       (rq),
    .mult_a   (mult_a),
    .mult_b   (mult_b),
    .mult_x   (mult_x),
    .stat_sel (stat_sel),
    .stat_cnt (stat_cnt)
  );

  always #5 clk = ~clk;

  // Hand-computed fp16 products (1*2, 2*3, .5*.5, -2*1, inf*1, 0*2, NaN*2, 4*4).
  logic [15:0] va [8] = '{16'h3C00, 16'h4000, 16'h3800, 16'hC000, 16'h7C00, 16'h0000, 16'h7E00, 16'h4400};
  logic [15:0] vb [8] = '{16'h4000, 16'h4200, 16'h3800, 16'h3C00, 16'h3C00, 16'h4000, 16'h4000, 16'h4400};
  logic [15:0] vp [8] = '{16'h4000, 16'h4600, 16'h3400, 16'hC000, 16'h7C00, 16'h0000, 16'h7E00, 16'h4C00};

  function automatic logic [15:0] mul_tab(input logic [15:0] a, input logic [15:0] b);
    for (int i = 0; i < 8; i++) if (va[i] == a && vb[i] == b) return vp[i];
    return 16'hDEAD;
  endfunction

  // Multiplier stand-in with LAT register stages.
  logic [15:0] xp [LAT];
  always @(posedge clk) begin
    xp[0] <= mul_tab(mult_a, mult_b);
    for (int k = 1; k < LAT; k++) xp[k] <= xp[k-1];
  end
  assign mult_x = xp[LAT-1];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [3:0]  oh;
    logic [15:0] d;
    int          at;
  } exp_t;
  exp_t sbq[$];
  exp_t me;

  int nvec = 0, nerr = 0, last_exit = -1;
  int opsel[4] = '{0, 0, 0, 0};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s @cyc %0d: got %0h want %0h", nm, cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && rq.res_valid !== '0) begin
      if (sbq.size() == 0) begin
        nvec++;
        nerr++;
        $display("FAIL unexpected_res @cyc %0d: got res_valid %0b want none", cyc, rq.res_valid);
      end else begin
        me = sbq.pop_front();
        chk("res_valid", 32'(rq.res_valid), 32'(me.oh));
        chk("res_data",  32'(rq.res_data),  32'(me.d));
        chk("res_cycle", 32'(cyc),          32'(me.at));
      end
    end
  end

  task automatic issue(input logic [3:0] v, input logic [3:0] eg);
    exp_t e;
    int   gi;
    for (int i = 0; i < NREQ; i++) begin
      rq.req_a[i] = va[opsel[i]];
      rq.req_b[i] = vb[opsel[i]];
    end
    rq.req_valid = v;
    @(negedge clk);
    chk("req_ready", 32'(rq.req_ready), 32'(eg));
    chk("busy", 32'(rq.busy), 32'(cyc <= last_exit));
    if (eg != '0) begin
      gi = 0;
      for (int i = 0; i < NREQ; i++) if (eg[i]) gi = i;
      e.oh = eg;
      e.d  = vp[opsel[gi]];
      e.at = cyc + 1 + LAT;
      sbq.push_back(e);
      last_exit = e.at;
    end
    @(posedge clk); #1;
    rq.req_valid = '0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      rq.req_valid = '0;
      @(negedge clk);
      chk("idle_ready", 32'(rq.req_ready), 32'd0);
      chk("busy", 32'(rq.busy), 32'(cyc <= last_exit));
      @(posedge clk); #1;
    end
  endtask

  task automatic drain();
    int k = 0;
    while (sbq.size() != 0 && k < 30) begin
      idle(1);
      k++;
    end
    nvec++;
    if (sbq.size() != 0) begin
      nerr++;
      $display("FAIL drain_timeout: got %0d pending want 0", sbq.size());
      sbq.delete();
    end
    idle(2);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    rq.req_valid = '0;
    sbq.delete();
    last_exit = -1;
    @(negedge clk);
    chk("rst_mult_a",    32'(mult_a),       32'd0);
    chk("rst_mult_b",    32'(mult_b),       32'd0);
    chk("rst_res_valid", 32'(rq.res_valid), 32'd0);
    chk("rst_busy",      32'(rq.busy),      32'd0);
    chk("rst_ready",     32'(rq.req_ready), 32'd0);
    chk("rst_stat",      32'(stat_cnt),     32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    rst          = 1'b1;
    stat_sel     = 3'd2;
    rq.req_valid = '0;
    rq.req_a     = '0;
    rq.req_b     = '0;
    @(posedge clk); #1;

    // Single request from requester 0 after reset.
    do_reset();
    opsel = '{0, 0, 0, 0};
    issue(4'b0001, 4'b0001);
    @(negedge clk);
    chk("mult_a", 32'(mult_a), 32'h3C00);
    chk("mult_b", 32'(mult_b), 32'h4000);
    @(posedge clk); #1;
    drain();

    // All four valid for 8 cycles: back-to-back round robin.
    do_reset();
    opsel = '{1, 2, 3, 7};
    for (int r = 0; r < 8; r++) issue(4'b1111, 4'b0001 << (r % 4));
    drain();

    // Pointer moved to 2, then requesters 1 and 3 contend.
    do_reset();
    opsel = '{4, 5, 6, 0};
    issue(4'b0010, 4'b0010);
    issue(4'b1010, 4'b1000);
    issue(4'b1010, 4'b0010);
    issue(4'b1010, 4'b1000);
    drain();

    // Idle gap between two issues keeps busy up until the second retires.
    do_reset();
    opsel = '{0, 1, 7, 3};
    issue(4'b0100, 4'b0100);
    idle(1);
    issue(4'b0100, 4'b0100);
    drain();

    // Reset with three operations in flight.
    do_reset();
    opsel = '{0, 1, 2, 3};
    issue(4'b0001, 4'b0001);
    issue(4'b0010, 4'b0010);
    issue(4'b0100, 4'b0100);
    do_reset();
    idle(LAT + 3);
    issue(4'b1111, 4'b0001);
    drain();

    // Grant statistics.
    do_reset();
    opsel    = '{0, 0, 6, 0};
    stat_sel = 3'd2;
`ifdef FP16_ARB_STATS_EN
    for (int r = 0; r < 70000; r++) issue(4'b0100, 4'b0100);
    drain();
    @(negedge clk);
    chk("stat_sat", 32'(stat_cnt), 32'hFFFF);
    stat_sel = 3'd7;
    #1;
    chk("stat_oob", 32'(stat_cnt), 32'd0);
    @(posedge clk); #1;
`else
    for (int r = 0; r < 5; r++) issue(4'b0100, 4'b0100);
    drain();
    @(negedge clk);
    chk("stat_off", 32'(stat_cnt), 32'd0);
    @(posedge clk); #1;
`endif

    chk("sb_empty", 32'(sbq.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #1500000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end
endmodule
